// File: rtl/sram_fifo_arbiter.sv
// sram_fifo_arbiter
// Shares one asynchronous SRAM between two FIFOs: FIFO_I (slave pushes,
// wireless master pops) and FIFO_O (master pushes, slave pops). The upper
// address bit selects the FIFO; each FIFO owns 2^(ADDR_W-1) words.
// One access at a time: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
//
// Build option: define SRAM_ARB_MASTER_PRIORITY_EN to make the wireless
// master win every contested grant. Without it the grant is round-robin.
module sram_fifo_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  // slave (SPI) side
  input  logic              slave_rd_req,
  input  logic              slave_wr_req,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              slave_ack,
  output logic              slave_hint,
  // master (wireless) side
  input  logic              master_rd_req,
  input  logic              master_wr_req,
  input  logic [DATA_W-1:0] master_wdata,
  output logic [DATA_W-1:0] master_rdata,
  output logic              master_ack,
  output logic              master_hint,
  // flush and status
  input  logic              flush_i,
  input  logic              flush_o,
  output logic [ADDR_W-1:0] fifo_i_count,
  output logic              fifo_i_empty,
  output logic              fifo_i_full,
  output logic [ADDR_W-1:0] fifo_o_count,
  output logic              fifo_o_empty,
  output logic              fifo_o_full,
  // SRAM pins
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              CE_n,
  output logic              OE_n,
  output logic              WE_n,
  output logic              LB_n,
  output logic              UB_n
);

  localparam int PTR_W  = ADDR_W - 1;
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] FULL_CNT  = {1'b1, {PTR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // latched access descriptor
  logic              side_master;
  logic              op_rd;
  logic [DATA_W-1:0] wdata_q;
  logic [WCNT_W-1:0] wcnt;
  logic              last_master;

  // FIFO bookkeeping
  logic [PTR_W-1:0]  wr_ptr_i;
  logic [PTR_W-1:0]  rd_ptr_i;
  logic [PTR_W-1:0]  wr_ptr_o;
  logic [PTR_W-1:0]  rd_ptr_o;
  logic              pend_i;
  logic              pend_o;

  // arbitration terms
  logic              s_rd;
  logic              s_wr;
  logic              m_rd;
  logic              m_wr;
  logic              s_any;
  logic              m_any;
  logic              flush_now_i;
  logic              flush_now_o;
  logic              pick_master;
  logic              grant;
  logic              grant_rd;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic              access_last;
  logic              done_upd;

  assign fifo_i_empty = (fifo_i_count == '0);
  assign fifo_i_full  = (fifo_i_count == FULL_CNT);
  assign fifo_o_empty = (fifo_o_count == '0);
  assign fifo_o_full  = (fifo_o_count == FULL_CNT);

  assign sram_dq_o    = wdata_q;
  assign access_last  = (state == ACCESS) && (wcnt == WCNT_LAST);
  assign done_upd     = (state == DONE);

  // Mask impossible requests, apply pending flushes, pick the winner
  always_comb begin
    s_rd        = slave_rd_req  & ~fifo_o_empty;
    s_wr        = slave_wr_req  & ~fifo_i_full;
    m_rd        = master_rd_req & ~fifo_i_empty;
    m_wr        = master_wr_req & ~fifo_o_full;
    s_any       = s_rd | s_wr;
    m_any       = m_rd | m_wr;
    flush_now_i = (state == IDLE) & (pend_i | flush_i);
    flush_now_o = (state == IDLE) & (pend_o | flush_o);
`ifdef SRAM_ARB_MASTER_PRIORITY_EN
    pick_master = m_any;
`else
    // the side that did not win last time wins a contested cycle
    pick_master = m_any & (~s_any | ~last_master);
`endif
    grant       = (state == IDLE) & ~flush_now_i & ~flush_now_o & (s_any | m_any);
    grant_rd    = pick_master ? m_rd : s_rd;
    grant_wdata = pick_master ? master_wdata : slave_wdata;
    grant_addr  = '0;
    if (pick_master) begin
      grant_addr = m_rd ? {1'b0, rd_ptr_i} : {1'b1, wr_ptr_o};
    end else begin
      grant_addr = s_rd ? {1'b1, rd_ptr_o} : {1'b0, wr_ptr_i};
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing of one SRAM access
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (wcnt == WCNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes, acks and ownership hints decoded from the access phase
  always_comb begin
    CE_n        = 1'b1;
    LB_n        = 1'b1;
    UB_n        = 1'b1;
    OE_n        = 1'b1;
    WE_n        = 1'b1;
    sram_dq_oe  = 1'b0;
    slave_ack   = 1'b0;
    master_ack  = 1'b0;
    slave_hint  = 1'b0;
    master_hint = 1'b0;
    case (state)
      SETUP: begin
        CE_n       = 1'b0;
        LB_n       = 1'b0;
        UB_n       = 1'b0;
        OE_n       = ~op_rd;
        sram_dq_oe = ~op_rd;
      end
      ACCESS: begin
        CE_n       = 1'b0;
        LB_n       = 1'b0;
        UB_n       = 1'b0;
        OE_n       = ~op_rd;
        WE_n       = op_rd;
        sram_dq_oe = ~op_rd;
      end
      DONE: begin
        // WE_n already released; data stays on the bus for hold time
        CE_n       = 1'b0;
        LB_n       = 1'b0;
        UB_n       = 1'b0;
        sram_dq_oe = ~op_rd;
        slave_ack  = ~side_master;
        master_ack = side_master;
      end
      default: ;
    endcase
    if (state != IDLE) begin
      slave_hint  = ~side_master;
      master_hint = side_master;
    end
  end

  // Latch the granted access and count ACCESS cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_master <= 1'b0;
      op_rd       <= 1'b0;
      sram_addr   <= '0;
      last_master <= 1'b1;
      wcnt        <= '0;
    end else begin
      if (grant) begin
        side_master <= pick_master;
        op_rd       <= grant_rd;
        sram_addr   <= grant_addr;
        last_master <= pick_master;
      end
      if (state == ACCESS) begin
        wcnt <= wcnt + WCNT_W'(1);
      end else begin
        wcnt <= '0;
      end
    end
  end

  // Write data is held with the access; it needs no reset
  always_ff @(posedge clk) begin
    if (grant) begin
      wdata_q <= grant_wdata;
    end
  end

  // Capture read data on the last ACCESS cycle for the owning side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_rdata  <= '0;
      master_rdata <= '0;
    end else if (access_last && op_rd) begin
      if (side_master) begin
        master_rdata <= sram_dq_i;
      end else begin
        slave_rdata <= sram_dq_i;
      end
    end
  end

  // Flush requests wait here until the arbiter is back in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_i <= 1'b0;
      pend_o <= 1'b0;
    end else if (state == IDLE) begin
      pend_i <= 1'b0;
      pend_o <= 1'b0;
    end else begin
      pend_i <= pend_i | flush_i;
      pend_o <= pend_o | flush_o;
    end
  end

  // FIFO_I pointers and count: slave pushes, master pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_i     <= '0;
      rd_ptr_i     <= '0;
      fifo_i_count <= '0;
    end else if (flush_now_i) begin
      wr_ptr_i     <= '0;
      rd_ptr_i     <= '0;
      fifo_i_count <= '0;
    end else if (done_upd && !side_master && !op_rd) begin
      wr_ptr_i     <= wr_ptr_i + PTR_W'(1);
      fifo_i_count <= fifo_i_count + ADDR_W'(1);
    end else if (done_upd && side_master && op_rd) begin
      rd_ptr_i     <= rd_ptr_i + PTR_W'(1);
      fifo_i_count <= fifo_i_count - ADDR_W'(1);
    end
  end

  // FIFO_O pointers and count: master pushes, slave pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_o     <= '0;
      rd_ptr_o     <= '0;
      fifo_o_count <= '0;
    end else if (flush_now_o) begin
      wr_ptr_o     <= '0;
      rd_ptr_o     <= '0;
      fifo_o_count <= '0;
    end else if (done_upd && side_master && !op_rd) begin
      wr_ptr_o     <= wr_ptr_o + PTR_W'(1);
      fifo_o_count <= fifo_o_count + ADDR_W'(1);
    end else if (done_upd && !side_master && op_rd) begin
      rd_ptr_o     <= rd_ptr_o + PTR_W'(1);
      fifo_o_count <= fifo_o_count - ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Bench for sram_fifo_arbiter. Uses a reduced ADDR_W so that full and
// pointer-wrap conditions are reachable quickly. A queue-based FIFO model
// predicts every cycle's outputs; directed steps add literal expectations.
module tb_sram_fifo_arbiter;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << (AW - 1);
  localparam int DP    = 2 + WC;   // phase number of the ack cycle

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          slave_rd_req = 1'b0, slave_wr_req = 1'b0;
  logic [DW-1:0] slave_wdata = '0, slave_rdata;
  logic          slave_ack, slave_hint;
  logic          master_rd_req = 1'b0, master_wr_req = 1'b0;
  logic [DW-1:0] master_wdata = '0, master_rdata;
  logic          master_ack, master_hint;
  logic          flush_i = 1'b0, flush_o = 1'b0;
  logic [AW-1:0] fifo_i_count, fifo_o_count;
  logic          fifo_i_empty, fifo_i_full, fifo_o_empty, fifo_o_full;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_i, sram_dq_o;
  logic          sram_dq_oe, CE_n, OE_n, WE_n, LB_n, UB_n;

  always #5 clk = ~clk;

  sram_fifo_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .slave_rd_req(slave_rd_req), .slave_wr_req(slave_wr_req),
    .slave_wdata(slave_wdata), .slave_rdata(slave_rdata),
    .slave_ack(slave_ack), .slave_hint(slave_hint),
    .master_rd_req(master_rd_req), .master_wr_req(master_wr_req),
    .master_wdata(master_wdata), .master_rdata(master_rdata),
    .master_ack(master_ack), .master_hint(master_hint),
    .flush_i(flush_i), .flush_o(flush_o),
    .fifo_i_count(fifo_i_count), .fifo_i_empty(fifo_i_empty), .fifo_i_full(fifo_i_full),
    .fifo_o_count(fifo_o_count), .fifo_o_empty(fifo_o_empty), .fifo_o_full(fifo_o_full),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
    .LB_n(LB_n), .UB_n(UB_n)
  );

  // Asynchronous SRAM behaviour
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_dq_i = (!CE_n && !OE_n) ? mem[sram_addr] : '0;
  always @(posedge clk) if (!CE_n && !WE_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            phase;     // 0 idle, 1 setup, 2..1+WC access, DP done
  bit            m_side;    // 1 = master owns the access
  bit            m_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] qi[$];
  logic [DW-1:0] qo[$];
  int            hi, ti, ho, to;
  bit            pend_i, pend_o, last_m;
  bit            sr, sw, mr, mw, s_any, m_any, win_m, fi, fo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0; qi.delete(); qo.delete();
      hi = 0; ti = 0; ho = 0; to = 0;
      pend_i = 0; pend_o = 0; last_m = 1; m_side = 0; m_rd = 0;
    end else if (phase == 0) begin
      fi = pend_i || flush_i;
      fo = pend_o || flush_o;
      pend_i = 0; pend_o = 0;
      if (fi || fo) begin
        if (fi) begin qi.delete(); hi = 0; ti = 0; end
        if (fo) begin qo.delete(); ho = 0; to = 0; end
      end else begin
        sr = slave_rd_req && qo.size() > 0;
        sw = slave_wr_req && qi.size() < DEPTH;
        mr = master_rd_req && qi.size() > 0;
        mw = master_wr_req && qo.size() < DEPTH;
        s_any = sr || sw;
        m_any = mr || mw;
        if (s_any || m_any) begin
`ifdef SRAM_ARB_MASTER_PRIORITY_EN
          win_m = m_any;
`else
          win_m = m_any && (!s_any || !last_m);
`endif
          m_side = win_m; last_m = win_m;
          if (win_m) begin
            m_rd = mr;
            if (mr) begin m_addr = AW'(hi); m_data = qi[0]; end
            else begin m_addr = AW'(DEPTH + to); m_data = master_wdata; end
          end else begin
            m_rd = sr;
            if (sr) begin m_addr = AW'(DEPTH + ho); m_data = qo[0]; end
            else begin m_addr = AW'(ti); m_data = slave_wdata; end
          end
          phase = 1;
        end
      end
    end else begin
      pend_i = pend_i || flush_i;
      pend_o = pend_o || flush_o;
      if (phase == DP) begin
        if (m_side && m_rd) begin void'(qi.pop_front()); hi = (hi + 1) % DEPTH; end
        else if (m_side) begin qo.push_back(m_data); to = (to + 1) % DEPTH; end
        else if (m_rd) begin void'(qo.pop_front()); ho = (ho + 1) % DEPTH; end
        else begin qi.push_back(m_data); ti = (ti + 1) % DEPTH; end
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  // ---------------- per-cycle compare + activity monitors ----------------
  bit            busy, done, acc;
  int            we_low, oe_low, ce_low, s_ack_cnt, m_ack_cnt;
  logic [AW-1:0] last_we_addr;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      busy = phase >= 1;
      done = phase == DP;
      acc  = phase >= 2 && phase <= 1 + WC;
      chk("slave_ack", slave_ack, done && !m_side);
      chk("master_ack", master_ack, done && m_side);
      chk("slave_hint", slave_hint, busy && !m_side);
      chk("master_hint", master_hint, busy && m_side);
      chk("CE_n", CE_n, !busy);
      chk("LB_n", LB_n, !busy);
      chk("UB_n", UB_n, !busy);
      chk("OE_n", OE_n, !(m_rd && busy && !done));
      chk("WE_n", WE_n, !(!m_rd && acc));
      chk("dq_oe", sram_dq_oe, busy && !m_rd);
      if (busy) chk("sram_addr", sram_addr, m_addr);
      if (busy && !m_rd) chk("dq_o", sram_dq_o, m_data);
      if (done && m_rd && m_side) chk("master_rdata", master_rdata, m_data);
      if (done && m_rd && !m_side) chk("slave_rdata", slave_rdata, m_data);
      chk("fifo_i_count", fifo_i_count, qi.size());
      chk("fifo_o_count", fifo_o_count, qo.size());
      chk("fifo_i_empty", fifo_i_empty, qi.size() == 0);
      chk("fifo_o_empty", fifo_o_empty, qo.size() == 0);
      chk("fifo_i_full", fifo_i_full, qi.size() == DEPTH);
      chk("fifo_o_full", fifo_o_full, qo.size() == DEPTH);
      if (!WE_n) begin we_low++; last_we_addr = sram_addr; end
      if (!OE_n) oe_low++;
      if (!CE_n) ce_low++;
      if (slave_ack) s_ack_cnt++;
      if (master_ack) m_ack_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    we_low = 0; oe_low = 0; ce_low = 0; s_ack_cnt = 0; m_ack_cnt = 0;
  endtask

  task automatic wait_any(input int maxc, output int who, output int lat);
    who = -1; lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk); #1;
      if (slave_ack === 1'b1) begin who = 0; lat = k; return; end
      if (master_ack === 1'b1) begin who = 1; lat = k; return; end
    end
    checks++; errors++;
    $display("FAIL ack_wait: no ack within %0d cycles", maxc);
  endtask

  int who, lat;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    clr_mon();
    tick(3);
    // reset state
    chk("rst_CE_n", CE_n, 1); chk("rst_OE_n", OE_n, 1); chk("rst_WE_n", WE_n, 1);
    chk("rst_LB_n", LB_n, 1); chk("rst_UB_n", UB_n, 1); chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_acks", {slave_ack, master_ack}, 0); chk("rst_hints", {slave_hint, master_hint}, 0);
    chk("rst_slave_rdata", slave_rdata, 0); chk("rst_master_rdata", master_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_counts", {fifo_i_count, fifo_o_count}, 0);
    chk("rst_empty", {fifo_i_empty, fifo_o_empty}, 2'b11);
    chk("rst_full", {fifo_i_full, fifo_o_full}, 2'b00);
    reset = 1'b0;

    // slave push 0xA5A5 into FIFO_I
    tick(1); clr_mon();
    slave_wdata = 16'hA5A5; slave_wr_req = 1'b1;
    wait_any(20, who, lat);
    chk("t1_who", who, 0); chk("t1_latency", lat, 4);
    @(negedge clk); slave_wr_req = 1'b0;
    chk("t1_we_low", we_low, 2); chk("t1_we_addr", last_we_addr, 6'h00);
    tick(1);
    chk("t1_count", fifo_i_count, 1); chk("t1_empty", fifo_i_empty, 0);

    // master pop of FIFO_I
    clr_mon(); master_rd_req = 1'b1;
    wait_any(20, who, lat);
    chk("t2_who", who, 1); chk("t2_latency", lat, 4);
    chk("t2_rdata", master_rdata, 16'hA5A5);
    @(negedge clk); master_rd_req = 1'b0;
    chk("t2_oe_low", oe_low, 3);
    tick(1);
    chk("t2_count", fifo_i_count, 0); chk("t2_empty", fifo_i_empty, 1);

    // both sides push continuously
    slave_wdata = 16'h1111; master_wdata = 16'h2222;
    slave_wr_req = 1'b1; master_wr_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any(20, who, lat);
`ifdef SRAM_ARB_MASTER_PRIORITY_EN
      chk("t3_order", who, 1);
`else
      chk("t3_order", who, k % 2);
`endif
      chk("t3_spacing", lat, (k == 0) ? 4 : 5);
      @(negedge clk);
      slave_wdata = 16'h1111 + 16'(k + 1); master_wdata = 16'h2222 + 16'(k + 1);
    end
    slave_wr_req = 1'b0; master_wr_req = 1'b0;
    tick(1);
`ifdef SRAM_ARB_MASTER_PRIORITY_EN
    chk("t3_counts", {fifo_i_count, fifo_o_count}, {6'd0, 6'd4});
`else
    chk("t3_counts", {fifo_i_count, fifo_o_count}, {6'd2, 6'd2});
`endif

    // flush both, then pops of empty FIFOs are masked
    flush_i = 1'b1; flush_o = 1'b1; tick(1);
    flush_i = 1'b0; flush_o = 1'b0; tick(1);
    chk("t4_flush_counts", {fifo_i_count, fifo_o_count}, 0);
    clr_mon(); master_rd_req = 1'b1; slave_rd_req = 1'b1;
    tick(12);
    master_rd_req = 1'b0; slave_rd_req = 1'b0;
    chk("t4_no_acks", s_ack_cnt + m_ack_cnt, 0); chk("t4_no_ce", ce_low, 0);

    // fill FIFO_O to full, then wrap
    master_wr_req = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      master_wdata = 16'h3000 + 16'(k);
      wait_any(12, who, lat);
      @(negedge clk);
    end
    chk("t5_top_addr", last_we_addr, 6'h3F);
    clr_mon(); tick(12);
    chk("t5_masked_push", m_ack_cnt, 0);
    chk("t5_full", fifo_o_full, 1); chk("t5_count", fifo_o_count, DEPTH);
    master_wr_req = 1'b0;
    slave_rd_req = 1'b1;
    wait_any(12, who, lat);
    chk("t5_pop0", slave_rdata, 16'h3000);
    @(negedge clk); slave_rd_req = 1'b0;
    master_wdata = 16'h4000; master_wr_req = 1'b1;
    wait_any(12, who, lat);
    @(negedge clk); master_wr_req = 1'b0;
    chk("t5_wrap_addr", last_we_addr, 6'h20);
    tick(1);
    chk("t5_full_again", fifo_o_full, 1);
    slave_rd_req = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      wait_any(12, who, lat);
      chk("t5_drain", slave_rdata, (k < DEPTH - 1) ? 16'h3001 + 16'(k) : 16'h4000);
      @(negedge clk);
    end
    clr_mon(); tick(10);
    slave_rd_req = 1'b0;
    chk("t5_masked_pop", s_ack_cnt, 0); chk("t5_empty", fifo_o_empty, 1);

    // reset during the ACCESS phase of a write
    slave_wdata = 16'hBEEF; slave_wr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("t6_we_active", WE_n, 0);
    @(negedge clk); reset = 1'b1; slave_wr_req = 1'b0;
    #1;
    chk("t6_we_abort", WE_n, 1); chk("t6_ce_abort", CE_n, 1); chk("t6_no_ack", slave_ack, 0);
    @(negedge clk); reset = 1'b0;
    tick(1);
    chk("t6_count", fifo_i_count, 0);

    // flush_i raised during a slave read of FIFO_O
    slave_wdata = 16'h5555; slave_wr_req = 1'b1;
    wait_any(12, who, lat);
    @(negedge clk); slave_wr_req = 1'b0;
    master_wdata = 16'h6666; master_wr_req = 1'b1;
    wait_any(12, who, lat);
    @(negedge clk); master_wr_req = 1'b0;
    slave_rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    wait_any(10, who, lat);
    chk("t7_who", who, 0); chk("t7_rdata", slave_rdata, 16'h6666);
    @(negedge clk); slave_rd_req = 1'b0;
    tick(2);
    chk("t7_counts", {fifo_i_count, fifo_o_count}, 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
